// File: rtl/btn_event_decoder_pkg.sv
// Shared state encoding and default timing constants for the button event decoder.
package btn_event_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam int LONG_TICKS_DEF   = 500;
  localparam int REPEAT_TICKS_DEF = 100;
  localparam int CNT_W_DEF        = 10;

endpackage

// File: rtl/btn_event_decoder_tick_counter.sv
// Tick-enabled counter that flags the tick on which it reaches terminal-1 and
// restarts from zero on that tick, so it never wraps.
module btn_event_decoder_tick_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             hit
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign hit = en && (count_reg == (terminal - CNT_W'(1)));

  always_comb begin
    count_next = count_reg;
    if (clr || hit) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into registered single-cycle press, release,
// short, long and auto-repeat events, timed in prescaler ticks.
module btn_event_decoder
  import btn_event_decoder_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  input  logic tick,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_TICKS);

  state_t state_reg;
  state_t state_next;

  logic press_next;
  logic release_next;
  logic short_next;
  logic long_next;
  logic repeat_next;

  logic             cnt_clr;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_terminal;

  // Count restarts on every press entry; a release also clears it so a release
  // coinciding with a threshold tick leaves no stale count behind.
  assign cnt_clr      = (state_reg == IDLE) || !btn_level;
  assign cnt_terminal = (state_reg == LONG) ? REPEAT_T : LONG_T;

  btn_event_decoder_tick_counter #(
    .CNT_W(CNT_W)
  ) u_tick_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (tick),
    .terminal(cnt_terminal),
    .hit     (cnt_hit)
  );

  always_comb begin
    state_next   = state_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (btn_level) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_next   = IDLE;
          release_next = 1'b1;
          short_next   = 1'b1;
        end else if (cnt_hit) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else if (cnt_hit) begin
          repeat_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      short_pulse   <= short_next;
      long_pulse    <= long_next;
      repeat_pulse  <= repeat_next;
    end
  end

  assign held = (state_reg != IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder: an elapsed-tick event model checked every
// cycle, plus literal expectations at the key cycles of each scenario.
module tb_btn_event_decoder;

  localparam int LT = 4;
  localparam int RT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_level = 1'b0;
  logic tick = 1'b0;
  logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

  btn_event_decoder #(
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .tick         (tick),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // {press, release, short, long, repeat, held}
  logic [5:0] obs;
  assign obs = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};

  // Model: a press starts an elapsed-tick count n; long fires at n==LT, repeats
  // whenever n-LT is a positive multiple of RT; release is short iff n<LT.
  bit         m_active = 1'b0;
  int         m_n = 0;
  logic [5:0] exp_vec = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_n      <= 0;
      exp_vec  <= '0;
    end else begin
      automatic logic [5:0] e = '0;
      automatic bit act = m_active;
      automatic int n = m_n;
      if (!act) begin
        if (btn_level) begin
          act  = 1'b1;
          n    = 0;
          e[5] = 1'b1;
        end
      end else if (!btn_level) begin
        act  = 1'b0;
        e[4] = 1'b1;
        e[3] = (n < LT);
      end else if (tick) begin
        n = n + 1;
        if (n == LT) e[2] = 1'b1;
        else if (n > LT && ((n - LT) % RT) == 0) e[1] = 1'b1;
      end
      e[0] = act;
      m_active <= act;
      m_n      <= n;
      exp_vec  <= e;
    end
  end

  int mc_checks = 0;
  int mc_pass = 0;
  int cyc_no = 0;

  always @(negedge clk) begin
    cyc_no <= cyc_no + 1;
    mc_checks <= mc_checks + 1;
    if (obs === exp_vec) begin
      mc_pass <= mc_pass + 1;
    end else begin
      $display("FAIL model_cycle%0d outputs=%b required=%b", cyc_no, obs, exp_vec);
    end
  end

  int lit_checks = 0;
  int lit_pass = 0;

  task automatic check_lit(input string name, input logic [5:0] req);
    lit_checks++;
    if (obs === req) begin
      lit_pass++;
      $display("ok   %s outputs=%b", name, obs);
    end else begin
      $display("FAIL %s outputs=%b required=%b", name, obs, req);
    end
  endtask

  // Drive inputs for the next edge, then return just after that edge.
  task automatic cyc(input logic b, input logic t);
    @(negedge clk);
    btn_level = b;
    tick      = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with button pressed and ticks running
    btn_level = 1'b1;
    tick      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_lit("reset_hold", 6'b000000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_lit("reset_release_press", 6'b100001);
    cyc(1'b1, 1'b1);
    check_lit("press_one_cycle", 6'b000001);
    cyc(1'b0, 1'b1);
    check_lit("reset_case_release", 6'b011000);
    cyc(1'b0, 1'b0);
    check_lit("idle_after_release", 6'b000000);

    // Short press
    cyc(1'b1, 1'b1);
    check_lit("short_press", 6'b100001);
    for (int i = 1; i <= 2; i++) begin
      cyc(1'b1, 1'b1);
      check_lit($sformatf("short_hold%0d", i), 6'b000001);
    end
    cyc(1'b0, 1'b1);
    check_lit("short_release", 6'b011000);
    cyc(1'b0, 1'b0);

    // Long press with auto-repeat
    cyc(1'b1, 1'b1);
    check_lit("long_press", 6'b100001);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b1);
      if (k == 4)
        check_lit($sformatf("long_tick%0d", k), 6'b000101);
      else if (k == 6 || k == 8 || k == 10)
        check_lit($sformatf("long_tick%0d", k), 6'b000011);
      else
        check_lit($sformatf("long_tick%0d", k), 6'b000001);
    end
    cyc(1'b0, 1'b1);
    check_lit("long_release", 6'b010000);
    cyc(1'b0, 1'b0);

    // Tick gating: tick every 5 clocks
    cyc(1'b1, 1'b0);
    check_lit("gate_press", 6'b100001);
    for (int i = 1; i <= 21; i++) begin
      cyc(1'b1, (i % 5) == 0);
      if (i == 20) check_lit("gate_long_clk20", 6'b000101);
      else if (i == 19 || i == 21) check_lit($sformatf("gate_clk%0d", i), 6'b000001);
    end
    cyc(1'b0, 1'b0);
    check_lit("gate_release", 6'b010000);
    cyc(1'b0, 1'b0);

    // Release coincident with the long-threshold tick
    cyc(1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1);
    check_lit("race_before", 6'b000001);
    cyc(1'b0, 1'b1);
    check_lit("race_release", 6'b011000);
    cyc(1'b0, 1'b1);
    check_lit("race_idle", 6'b000000);

    // Asynchronous reset while in LONG
    cyc(1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b1);
    check_lit("midrst_long", 6'b000101);
    #2;
    rst = 1'b0;
    #1;
    check_lit("midrst_async_clear", 6'b000000);
    @(negedge clk);
    btn_level = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      check_lit($sformatf("midrst_idle%0d", i), 6'b000000);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", mc_pass + lit_pass, mc_checks + lit_checks);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Consumes the clean, debounced button level from the input debouncer and converts it into single-cycle user events: press, release, short-press, long-press and auto-repeat.
- Sits between the debouncer and the timer/counter control logic. All timing is counted in enable ticks from the system prescaler, never in raw clocks.

Parameters:
- LONG_TICKS, 500, ticks a press must be held before it counts as a long press; legal range 1..2^CNT_W-1.
- REPEAT_TICKS, 100, ticks between auto-repeat pulses once long; legal range 1..2^CNT_W-1.
- CNT_W, 10, width of the internal tick counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_level  in  1  debounced button level; 1 = pressed. Synchronous to clk.
- tick  in  1  one-clk-wide timebase enable.
- press_pulse  out  1  1-clk pulse on press.
- release_pulse  out  1  1-clk pulse on release.
- short_pulse  out  1  1-clk pulse on release before long threshold.
- long_pulse  out  1  1-clk pulse when long threshold is reached.
- repeat_pulse  out  1  1-clk pulse every REPEAT_TICKS while long.
- held  out  1  level; 1 while state != IDLE.

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is asynchronous and active-low. In reset: state = IDLE, count = 0, all pulse outputs = 0, held = 0.
- Outputs are registered. Any event decided at edge N is visible from edge N to edge N+1, then cleared.
- FSM has three states: IDLE, PRESSED, LONG.
- IDLE:
  - btn_level=1 -> PRESSED, count=0, press_pulse=1.
  - Otherwise stay in IDLE.
- PRESSED:
  - btn_level=0 -> IDLE, release_pulse=1 and short_pulse=1 in the same cycle.
  - Else if tick=1 and count==LONG_TICKS-1 -> LONG, count=0, long_pulse=1.
  - Else if tick=1 -> count+1.
  - tick=0 -> count holds.
- LONG:
  - btn_level=0 -> IDLE, release_pulse=1, no short_pulse.
  - Else if tick=1 and count==REPEAT_TICKS-1 -> count=0, repeat_pulse=1, stay in LONG.
  - Else if tick=1 -> count+1.
- Simultaneous release and threshold tick in the same cycle: release wins. No long_pulse or repeat_pulse is issued; a release from PRESSED is still classified short.
- held goes 1 the cycle press_pulse goes 1, and 0 the cycle release_pulse goes 1.
- Counter never wraps: it is cleared on every threshold and on every entry to PRESSED.
- Event latency: press_pulse is registered at the first edge where btn_level=1 is sampled in IDLE, i.e. a one-clock registered event.
- Repeat spacing: the first repeat_pulse occurs REPEAT_TICKS ticks after long_pulse.
- Reset mid-press: everything returns to IDLE, with no release_pulse emitted. If btn_level is still 1 after reset deasserts, a fresh press_pulse fires on the first edge.
- At most one of press/release/long/repeat is asserted in any cycle. short_pulse only ever coincides with release_pulse.
- Out-of-range parameters are a configuration error; there is no runtime check.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE=2'd0, PRESSED=2'd1, LONG=2'd2;
  - default tick constants LONG_TICKS_DEF=500 and REPEAT_TICKS_DEF=100, so the top level and the bench use the same values.
- One sub-module is natural: tick_counter, a CNT_W-bit counter.
  - Inputs: clk, rst, clr, en (tick), terminal value.
  - Output: a terminal-hit flag, defined as count==terminal-1 while en=1.
  - btn_event_decoder instantiates it once and muxes the terminal between LONG_TICKS and REPEAT_TICKS by state.

Test Plan (LONG_TICKS=4, REPEAT_TICKS=2, CNT_W=4 unless stated):
- Reset: hold rst=0 with btn_level=1 and tick=1 -> all outputs 0, held=0. Release rst -> press_pulse=1 for exactly 1 clk on the next edge, then held=1.
- Short press: btn_level high for 3 ticks (tick every clk), then low -> press_pulse, 3 clks later release_pulse=1 and short_pulse=1 in the same cycle, long_pulse never asserted.
- Long press with repeat: btn_level high for 10 ticks -> long_pulse on the 4th tick after press, repeat_pulse on ticks 6, 8 and 10; on release, release_pulse=1 and short_pulse=0.
- Tick gating: tick every 5 clks, press held 22 clks -> long_pulse exactly after the 4th tick (clk ~20), and count frozen between ticks.
- Race: release coincident with the 4th tick -> release_pulse=1, short_pulse=1, long_pulse=0, state IDLE.
- Mid-operation reset: assert rst in LONG -> outputs 0 within the same cycle (asynchronous), no release_pulse; after deassert with btn_level=0, state stays IDLE.
